oled_line_arbiter: RTL and testbench



---
 rtl/oled_line_arbiter.sv | 150 +++++++++++++++
 tb/tb_oled_line_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_line_arbiter.sv
// Round-robin arbiter sharing four 128-bit OLED text rows among NUM_REQ writers.
// Changed rows are batched into one refresh handshake; rows stay frozen while it is pending.
module oled_line_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BATCH = 8,
    parameter logic [127:0] BLANK    = {16{8'h20}}
) (
    input  logic                     GCLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [2*NUM_REQ-1:0]     ROW,
    input  logic [128*NUM_REQ-1:0]   TEXT,
    output logic [NUM_REQ-1:0]       ACK,
    output logic [127:0]             OLED_S0,
    output logic [127:0]             OLED_S1,
    output logic [127:0]             OLED_S2,
    output logic [127:0]             OLED_S3,
    output logic [3:0]               DIRTY_ROWS,
    output logic                     REFRESH_REQ,
    input  logic                     REFRESH_ACK
);

    localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BatchW = $clog2(MAX_BATCH + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRefresh} state_e;

    state_e               state_q, state_d;
    logic [127:0]         rows_q [4];
    logic [127:0]         rows_d [4];
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [3:0]           dirty_q, dirty_d;
    logic                 refresh_q, refresh_d;
    logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]      gnt_q, gnt_d;
    logic [BatchW-1:0]    batch_q, batch_d;

    logic [127:0]         text_arr [NUM_REQ];
    logic [1:0]           row_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   eff;
    logic [2*NUM_REQ-1:0] eff_rot;
    logic [PtrW-1:0]      pick;
    logic                 start_refresh;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            text_arr[i] = TEXT[128*i +: 128];
            row_arr[i]  = ROW[2*i +: 2];
        end
    end

    // A requester being acknowledged this cycle must not be granted again.
    assign eff     = REQ & ~ack_q;
    assign eff_rot = {eff, eff} >> rr_ptr_q;

    always_comb begin
        logic        found;
        int unsigned idx;
        found = 1'b0;
        idx   = 0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && eff_rot[i]) begin
                found = 1'b1;
                idx   = int'(rr_ptr_q) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                pick  = PtrW'(idx);
            end
        end
    end

    assign start_refresh = (dirty_q != 4'd0) &&
                           ((eff == '0) || (batch_q == BatchW'(MAX_BATCH)));

    always_ff @(posedge GCLK) begin
        if (RST) begin
            state_q   <= StIdle;
            for (int i = 0; i < 4; i++) rows_q[i] <= BLANK;
            ack_q     <= '0;
            dirty_q   <= '0;
            refresh_q <= 1'b0;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            batch_q   <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            ack_q     <= ack_d;
            dirty_q   <= dirty_d;
            refresh_q <= refresh_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            batch_q   <= batch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_refresh)  state_d = StRefresh;
                else if (eff != '0) state_d = StWrite;
            end
            StWrite:   state_d = StIdle;
            StRefresh: if (REFRESH_ACK) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        rows_d    = rows_q;
        ack_d     = '0;
        dirty_d   = dirty_q;
        refresh_d = refresh_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        batch_d   = batch_q;
        unique case (state_q)
            StIdle: begin
                if (start_refresh)  refresh_d = 1'b1;
                else if (eff != '0) gnt_d = pick;
            end
            StWrite: begin
                // ROW/TEXT are taken as presented during this cycle.
                rows_d[row_arr[gnt_q]]  = text_arr[gnt_q];
                dirty_d[row_arr[gnt_q]] = 1'b1;
                ack_d[gnt_q]            = 1'b1;
                rr_ptr_d = (gnt_q == PtrW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                if (batch_q != BatchW'(MAX_BATCH)) batch_d = batch_q + 1'b1;
            end
            StRefresh: begin
                if (REFRESH_ACK) begin
                    refresh_d = 1'b0;
                    dirty_d   = '0;
                    batch_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign ACK         = ack_q;
    assign OLED_S0     = rows_q[0];
    assign OLED_S1     = rows_q[1];
    assign OLED_S2     = rows_q[2];
    assign OLED_S3     = rows_q[3];
    assign DIRTY_ROWS  = dirty_q;
    assign REFRESH_REQ = refresh_q;

endmodule

// File: tb/tb_oled_line_arbiter.sv
// Self-checking bench for oled_line_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of rows, dirty bits, round-robin pointer and batch.
module tb_oled_line_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 8;
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic               GCLK = 1'b0;
    logic               RST = 1'b1;
    logic [N-1:0]       REQ = '0;
    logic [2*N-1:0]     ROW = '0;
    logic [128*N-1:0]   TEXT = '0;
    logic [N-1:0]       ACK;
    logic [127:0]       OLED_S0, OLED_S1, OLED_S2, OLED_S3;
    logic [3:0]         DIRTY_ROWS;
    logic               REFRESH_REQ;
    logic               REFRESH_ACK = 1'b0;
    logic [511:0]       dut_rows;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    logic [127:0] m_rows [4];
    logic [3:0]   m_dirty;
    int           m_rr;
    int           m_batch;
    logic [N-1:0] last_ack;

    oled_line_arbiter #(
        .NUM_REQ  (N),
        .MAX_BATCH(MAXB),
        .BLANK    (BLANK)
    ) dut (
        .GCLK       (GCLK),
        .RST        (RST),
        .REQ        (REQ),
        .ROW        (ROW),
        .TEXT       (TEXT),
        .ACK        (ACK),
        .OLED_S0    (OLED_S0),
        .OLED_S1    (OLED_S1),
        .OLED_S2    (OLED_S2),
        .OLED_S3    (OLED_S3),
        .DIRTY_ROWS (DIRTY_ROWS),
        .REFRESH_REQ(REFRESH_REQ),
        .REFRESH_ACK(REFRESH_ACK)
    );

    always #5 GCLK = ~GCLK;
    assign dut_rows = {OLED_S3, OLED_S2, OLED_S1, OLED_S0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] model_flat();
        return {m_rows[3], m_rows[2], m_rows[1], m_rows[0]};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] cand);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rand_text();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge GCLK);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rows[i] = BLANK;
        m_dirty  = '0;
        m_rr     = 0;
        m_batch  = 0;
        last_ack = '0;
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        REQ = '0;
        REFRESH_ACK = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        model_reset();
    endtask

    task automatic set_req(input int i, input logic [1:0] r, input logic [127:0] t);
        REQ[i]          = 1'b1;
        ROW[2*i +: 2]   = r;
        TEXT[128*i +: 128] = t;
    endtask

    // One arbitration decision from an IDLE cycle: a write, a refresh, or an idle cycle.
    // mode 0: granted requester drops REQ; 1: keeps requesting; 2: random re-roll.
    task automatic do_txn(input int mode, input int hold, output int g);
        logic [N-1:0] cand;
        int r;
        cand = REQ & ~last_ack;
        if (m_dirty != 0 && (cand == '0 || m_batch == MAXB)) begin
            g = -1;
            tick();
            n_total++;
            if (REFRESH_REQ !== 1'b1 || ACK !== '0 || DIRTY_ROWS !== m_dirty)
                $display("FAIL refresh_enter: req=%b ack=%b dirty=%b, want req=1 ack=0 dirty=%b",
                         REFRESH_REQ, ACK, DIRTY_ROWS, m_dirty);
            else n_pass++;
            for (int c = 0; c < hold; c++) begin
                tick();
                n_total++;
                if (REFRESH_REQ !== 1'b1 || ACK !== '0 || DIRTY_ROWS !== m_dirty ||
                    dut_rows !== model_flat())
                    $display("FAIL refresh_hold: req=%b ack=%b dirty=%b, want req=1 ack=0 dirty=%b",
                             REFRESH_REQ, ACK, DIRTY_ROWS, m_dirty);
                else n_pass++;
            end
            REFRESH_ACK = 1'b1;
            tick();
            REFRESH_ACK = 1'b0;
            m_dirty  = '0;
            m_batch  = 0;
            last_ack = '0;
            n_total++;
            if (REFRESH_REQ !== 1'b0 || DIRTY_ROWS !== 4'b0000 || ACK !== '0)
                $display("FAIL refresh_exit: req=%b dirty=%b ack=%b, want 0 0000 0000",
                         REFRESH_REQ, DIRTY_ROWS, ACK);
            else n_pass++;
            if (mode == 2 && REQ == '0)
                set_req($urandom_range(0, N-1), 2'($urandom_range(0, 3)), rand_text());
        end else if (cand != '0) begin
            g = rr_pick(cand);
            tick();
            n_total++;
            if (ACK !== '0 || REFRESH_REQ !== 1'b0 || dut_rows !== model_flat())
                $display("FAIL write_cycle: ack=%b refresh=%b, want ack=0 refresh=0 rows unchanged",
                         ACK, REFRESH_REQ);
            else n_pass++;
            tick();
            r = ROW[2*g +: 2];
            m_rows[r]  = TEXT[128*g +: 128];
            m_dirty[r] = 1'b1;
            m_rr       = (g + 1) % N;
            if (m_batch < MAXB) m_batch++;
            last_ack   = N'(1) << g;
            n_total++;
            if (ACK !== last_ack || dut_rows !== model_flat() || DIRTY_ROWS !== m_dirty ||
                REFRESH_REQ !== 1'b0)
                $display("FAIL grant: ack=%b dirty=%b rows=%h, want ack=%b dirty=%b rows=%h",
                         ACK, DIRTY_ROWS, dut_rows, last_ack, m_dirty, model_flat());
            else n_pass++;
            if (mode == 0) REQ[g] = 1'b0;
            else if (mode == 2) begin
                for (int i = 0; i < N; i++) begin
                    if (i == g || !REQ[i]) begin
                        if ($urandom_range(0, 3) != 0)
                            set_req(i, 2'($urandom_range(0, 3)), rand_text());
                        else REQ[i] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        REQ[i] = 1'b0;
                    end
                end
            end
        end else begin
            g = -2;
            tick();
            last_ack = '0;
            n_total++;
            if (ACK !== '0 || REFRESH_REQ !== 1'b0)
                $display("FAIL idle: ack=%b refresh=%b, want 0 0", ACK, REFRESH_REQ);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if (dut_rows !== {4{BLANK}}) $display("FAIL reset_rows: rows=%h, want all blank", dut_rows);
        else n_pass++;
        n_total++;
        if (ACK !== '0 || DIRTY_ROWS !== 4'b0 || REFRESH_REQ !== 1'b0)
            $display("FAIL reset_ctrl: ack=%b dirty=%b refresh=%b, want 0", ACK, DIRTY_ROWS, REFRESH_REQ);
        else n_pass++;
    endtask

    task automatic test_single_write();
        logic [127:0] spi_txt;
        int g;
        spi_txt = "SPI interface   ";
        apply_reset();
        set_req(0, 2'd2, spi_txt);
        do_txn(0, 0, g);
        n_total++;
        if (OLED_S2 !== spi_txt || OLED_S0 !== BLANK || OLED_S1 !== BLANK || OLED_S3 !== BLANK ||
            ACK !== 4'b0001 || DIRTY_ROWS !== 4'b0100)
            $display("FAIL single_write: s2=%h ack=%b dirty=%b, want s2=%h ack=0001 dirty=0100",
                     OLED_S2, ACK, DIRTY_ROWS, spi_txt);
        else n_pass++;
        do_txn(0, 2, g);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] ack_seen [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int g;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'(i), rand_text());
        for (int k = 0; k < 5; k++) begin
            do_txn(1, 0, g);
            ack_seen[k] = ACK;
        end
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (ack_seen[k] !== (N'(1) << exp_order[k]) ||
                (k > 0 && ack_seen[k] === ack_seen[k-1]))
                $display("FAIL rr_order[%0d]: ack=%b, want %b", k, ack_seen[k],
                         N'(1) << exp_order[k]);
            else n_pass++;
        end
        REQ = '0;
    endtask

    task automatic test_batch();
        int g;
        int acks;
        acks = 0;
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'(i), rand_text());
        for (int k = 0; k < 12; k++) begin
            do_txn(1, 3, g);
            if (ACK != '0) acks++;
            if (g == -1) break;
        end
        n_total++;
        if (acks !== MAXB) $display("FAIL batch_count: acks before refresh=%0d, want %0d", acks, MAXB);
        else n_pass++;
        do_txn(1, 0, g);
        n_total++;
        if (ACK !== 4'b0001) $display("FAIL batch_resume: ack=%b, want 0001", ACK);
        else n_pass++;
        REQ = '0;
    endtask

    task automatic test_freeze();
        logic [127:0] t1;
        int g;
        apply_reset();
        set_req(0, 2'd3, rand_text());
        do_txn(0, 0, g);
        tick();
        n_total++;
        if (REFRESH_REQ !== 1'b1 || DIRTY_ROWS !== 4'b1000)
            $display("FAIL freeze_enter: refresh=%b dirty=%b, want 1 1000", REFRESH_REQ, DIRTY_ROWS);
        else n_pass++;
        t1 = rand_text();
        set_req(1, 2'd1, t1);
        for (int c = 0; c < 50; c++) begin
            tick();
            n_total++;
            if (ACK !== '0 || REFRESH_REQ !== 1'b1 || DIRTY_ROWS !== 4'b1000 ||
                dut_rows !== model_flat())
                $display("FAIL freeze_hold[%0d]: ack=%b refresh=%b dirty=%b, want 0000 1 1000",
                         c, ACK, REFRESH_REQ, DIRTY_ROWS);
            else n_pass++;
        end
        REFRESH_ACK = 1'b1;
        tick();
        REFRESH_ACK = 1'b0;
        m_dirty  = '0;
        m_batch  = 0;
        last_ack = '0;
        n_total++;
        if (REFRESH_REQ !== 1'b0 || DIRTY_ROWS !== 4'b0)
            $display("FAIL freeze_release: refresh=%b dirty=%b, want 0 0000", REFRESH_REQ, DIRTY_ROWS);
        else n_pass++;
        do_txn(0, 0, g);
        n_total++;
        if (ACK !== 4'b0010 || OLED_S1 !== t1)
            $display("FAIL freeze_write: ack=%b s1=%h, want 0010 %h", ACK, OLED_S1, t1);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [127:0] ta, tb;
        int g;
        ta = "AAAAAAAAAAAAAAAA";
        tb = "BBBBBBBBBBBBBBBB";
        apply_reset();
        set_req(0, 2'd0, ta);
        set_req(1, 2'd0, tb);
        do_txn(0, 0, g);
        do_txn(0, 0, g);
        n_total++;
        if (OLED_S0 !== tb || DIRTY_ROWS !== 4'b0001)
            $display("FAIL collision: s0=%h dirty=%b, want %h 0001", OLED_S0, DIRTY_ROWS, tb);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int g;
        apply_reset();
        set_req(0, 2'd1, rand_text());
        tick();
        RST = 1'b1;
        REQ = '0;
        tick();
        RST = 1'b0;
        model_reset();
        n_total++;
        if (dut_rows !== {4{BLANK}} || ACK !== '0 || REFRESH_REQ !== 1'b0 || DIRTY_ROWS !== 4'b0)
            $display("FAIL reset_in_write: ack=%b refresh=%b dirty=%b rows=%h, want reset values",
                     ACK, REFRESH_REQ, DIRTY_ROWS, dut_rows);
        else n_pass++;
        REFRESH_ACK = 1'b1;
        tick();
        REFRESH_ACK = 1'b0;
        tick();
        n_total++;
        if (REFRESH_REQ !== 1'b0 || DIRTY_ROWS !== 4'b0 || ACK !== '0)
            $display("FAIL stray_refresh_ack: refresh=%b dirty=%b ack=%b, want 0", REFRESH_REQ,
                     DIRTY_ROWS, ACK);
        else n_pass++;

        set_req(0, 2'd2, rand_text());
        do_txn(0, 0, g);
        tick();
        n_total++;
        if (REFRESH_REQ !== 1'b1) $display("FAIL reset_refresh_setup: refresh=%b, want 1", REFRESH_REQ);
        else n_pass++;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_reset();
        n_total++;
        if (dut_rows !== {4{BLANK}} || ACK !== '0 || REFRESH_REQ !== 1'b0 || DIRTY_ROWS !== 4'b0)
            $display("FAIL reset_in_refresh: ack=%b refresh=%b dirty=%b, want reset values",
                     ACK, REFRESH_REQ, DIRTY_ROWS);
        else n_pass++;
        REFRESH_ACK = 1'b1;
        tick();
        REFRESH_ACK = 1'b0;
        n_total++;
        if (REFRESH_REQ !== 1'b0 || DIRTY_ROWS !== 4'b0)
            $display("FAIL late_refresh_ack: refresh=%b dirty=%b, want 0 0000", REFRESH_REQ, DIRTY_ROWS);
        else n_pass++;
        set_req(1, 2'd3, rand_text());
        set_req(3, 2'd0, rand_text());
        do_txn(0, 0, g);
        n_total++;
        if (ACK !== 4'b0010) $display("FAIL rr_after_reset: ack=%b, want 0010", ACK);
        else n_pass++;
        REQ = '0;
    endtask

    task automatic test_random();
        int g;
        apply_reset();
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1) set_req(i, 2'($urandom_range(0, 3)), rand_text());
        if (REQ == '0) set_req(2, 2'd1, rand_text());
        for (int k = 0; k < 300; k++) do_txn(2, $urandom_range(0, 3), g);
        REQ = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_batch();
        test_freeze();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
